vec_mem_arbiter: RTL



---
 rtl/vec_mem_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vec_mem_arbiter.sv
// Round-robin arbiter and access sequencer for the single-port vector data memory.
// Requester 0 is the pipeline MEM stage, requester 1 the host/DMA vector loader.
//
// state | meaning
// IDLE  | no access in flight; arbitrate and latch the winner's request
// ISSUE | one-cycle mem_en strobe with latched we/addr/wdata
// WAIT  | read-latency down-count; load data captured at terminal count
// DONE  | one-cycle done pulse to the owner
module vec_mem_arbiter #(
  parameter int ADDR_W  = 21,
  parameter int DATA_W  = 192,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_done,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t            state, state_nxt;
  logic              rr_ptr;
  logic              owner;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CNT_W-1:0]  cnt;
  logic              any_req;
  logic              win;

  assign any_req = p0_req | p1_req;
  // a lone requester wins outright; a tie goes to rr_ptr
  assign win = (p0_req & p1_req) ? rr_ptr : p1_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    p0_done   = 1'b0;
    p1_done   = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    case (state)
      IDLE: begin
        if (any_req) state_nxt = ISSUE;
      end
      ISSUE: begin
        busy      = 1'b1;
        p0_gnt    = ~owner;
        p1_gnt    = owner;
        mem_en    = 1'b1;
        mem_we    = lat_we;
        state_nxt = WAIT;
      end
      WAIT: begin
        busy   = 1'b1;
        p0_gnt = ~owner;
        p1_gnt = owner;
        if (cnt == '0) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        p0_gnt    = ~owner;
        p1_gnt    = owner;
        p0_done   = ~owner;
        p1_done   = owner;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr    <= 1'b0;
      owner     <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      cnt       <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= win;
            rr_ptr    <= ~win;
            lat_we    <= win ? p1_we    : p0_we;
            lat_addr  <= win ? p1_addr  : p0_addr;
            lat_wdata <= win ? p1_wdata : p0_wdata;
          end
        end
        ISSUE: cnt <= CNT_LOAD;
        WAIT: begin
          if (cnt == '0) begin
            if (!lat_we) rdata <= mem_rdata;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
